regfile_dump: RTL
=================

# regfile_dump

Sequential reader that walks a contiguous address window of the register file through one of its asynchronous read ports and streams the contents out as a valid/ready word stream, one word per cycle after a one-cycle prefetch. It sits between the register file read port and a debug/trace sink: the debug/trace logic writes registers, and this block reads them back out. It owns the read address of that port while busy.

## Interface
- BW_DATA, 32, register word width
- BW_ADDR, 5, register address width (2**BW_ADDR entries)

- i_clk  input  1  clock, all state updates on rising edge
- i_rstn  input  1  synchronous active-low reset
- i_start  input  1  start request; sampled only in IDLE
- i_base_addr  input  BW_ADDR  first address to dump; latched on accepted start
- i_count  input  BW_ADDR+1  number of words, 0..2**BW_ADDR; latched on accepted start
- o_rf_rd_addr  output  BW_ADDR  read address to register file port
- i_rf_rd_data  input  BW_DATA  combinational read data for o_rf_rd_addr
- o_dout_valid  output  1  stream word valid
- i_dout_ready  input  1  sink accepts word
- o_dout_data  output  BW_DATA  stream word
- o_dout_last  output  1  marks final beat of the dump
- o_busy  output  1  high from accepted start until the done pulse, inclusive
- o_done  output  1  one-cycle pulse after the final handshake

## Operation
- States: IDLE, FETCH, SEND, CSUM (macro only), DONE.
- IDLE: o_busy=0. i_start=1 latches base/count, sets rd_addr=base, remaining=count. count≠0 goes to FETCH. count=0 goes to DONE, or to CSUM with the macro.
- FETCH (1 cycle): o_dout_data<=i_rf_rd_data, rd_addr<=rd_addr+1, remaining--, go SEND.
- SEND: o_dout_valid=1. Data, last and valid stay stable until a handshake (valid&ready).
  - Handshake with remaining≠0: o_dout_data<=i_rf_rd_data, rd_addr++, remaining--, stay in SEND. No bubble.
  - Handshake with remaining=0: go to DONE, or to CSUM with the macro.
- o_dout_last=1 on the final register beat only when the macro is off.
- DONE (1 cycle): o_done=1, o_busy=1, then IDLE.
- Address arithmetic is modulo 2**BW_ADDR: base=31, count=3 reads 31, 0, 1.
- i_start outside IDLE is ignored.
- Each word reflects register content at the cycle it is captured (FETCH, or the preceding handshake). A concurrent write becomes visible only if it lands before capture.
- i_rstn=0 in any state takes effect at the next edge: state IDLE, all outputs 0. No partial done pulse.

## Timing
- Reset values: o_rf_rd_addr=0, o_dout_valid=0, o_dout_data=0, o_dout_last=0, o_busy=0, o_done=0.
- Start is sampled at edge 0. FETCH occupies cycle 1. o_dout_valid first rises in cycle 2.
- With ready held high, N words take N+1 cycles after start. o_done follows in the cycle after the last handshake.
- Outputs are registered, except that o_rf_rd_addr is a registered address counter driven directly.
- When o_busy falls, a new start may be issued in the same cycle.

## Configuration
- REGFILE_DUMP_CHECKSUM_EN defined:
  - After the last register word, a CSUM beat carries the XOR of all words sent, with o_dout_last=1.
  - count=0 emits a single CSUM beat of 0 with last=1.
  - CSUM obeys the same valid/ready rules. Its handshake leads to DONE.
- Undefined:
  - The CSUM state and accumulator do not exist. Last is flagged on the final register word.
  - count=0 produces no beats, only the done pulse two cycles after start.

## Structure
- Shared package regfile_pkg: BW_DATA/BW_ADDR defaults and the dump state enum.
- Optional sub-module regfile_dump_csum: XOR accumulator with clear and enable, instantiated only under the macro.

## Test plan
- Regfile preloaded with addr*0x11, base=2, count=4, ready=1 → words 0x22,0x33,0x44,0x55 on consecutive cycles 2..5; last with 0x55; o_done in cycle 6.
- Same dump with ready toggled 1,0,0,1,… → no word dropped or duplicated; data and last stable while valid&!ready.
- base=30, count=4 → addresses 30,31,0,1 read in order (wrap-around).
- count=0 → no valid beats (macro off); o_done pulse; o_busy high 2 cycles.
- i_rstn=0 mid-SEND with valid high → next cycle all outputs 0, state IDLE; a fresh start then dumps correctly. A start pulsed while busy is ignored.
- Macro on, words 0xA5A5A5A5,0x0F0F0F0F → extra beat 0xAAAAAAAA with last=1; last not set on either register word.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file dump block: default widths and FSM states.
// The ST_CSUM state only exists when REGFILE_DUMP_CHECKSUM_EN is defined.
package regfile_pkg;

  localparam int DEF_BW_DATA = 32;
  localparam int DEF_BW_ADDR = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
`ifdef REGFILE_DUMP_CHECKSUM_EN
    ST_CSUM  = 3'd3,
`endif
    ST_DONE  = 3'd4
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_if.sv
// Bus bundle for regfile_dump: start/command, register-file read port and output stream.
// Signal prefixes are from the dump block's point of view (master modport).
interface regfile_dump_if
  import regfile_pkg::*;
#(
  parameter int BW_DATA = DEF_BW_DATA,
  parameter int BW_ADDR = DEF_BW_ADDR
) ();

  logic               i_start;
  logic [BW_ADDR-1:0] i_base_addr;
  logic [BW_ADDR:0]   i_count;
  logic [BW_ADDR-1:0] o_rf_rd_addr;
  logic [BW_DATA-1:0] i_rf_rd_data;
  logic               o_dout_valid;
  logic               i_dout_ready;
  logic [BW_DATA-1:0] o_dout_data;
  logic               o_dout_last;
  logic               o_busy;
  logic               o_done;

  modport master (
    input  i_start, i_base_addr, i_count, i_rf_rd_data, i_dout_ready,
    output o_rf_rd_addr, o_dout_valid, o_dout_data, o_dout_last, o_busy, o_done
  );

  modport slave (
    output i_start, i_base_addr, i_count, i_rf_rd_data, i_dout_ready,
    input  o_rf_rd_addr, o_dout_valid, o_dout_data, o_dout_last, o_busy, o_done
  );

endinterface

// File: rtl/regfile_dump_csum.sv
// XOR accumulator over the words captured during a dump; cleared on an accepted start.
// Only instantiated when REGFILE_DUMP_CHECKSUM_EN is defined.
module regfile_dump_csum
  import regfile_pkg::*;
#(
  parameter int BW_DATA = DEF_BW_DATA
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [BW_DATA-1:0] i_data,
  output logic [BW_DATA-1:0] o_csum
);

  logic [BW_DATA-1:0] r_acc;

  // Running XOR of every captured word
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_acc <= {BW_DATA{1'b0}};
    end else if (i_clr) begin
      r_acc <= {BW_DATA{1'b0}};
    end else if (i_en) begin
      r_acc <= r_acc ^ i_data;
    end else begin
      r_acc <= r_acc;
    end
  end

  assign o_csum = r_acc;

endmodule

// File: rtl/regfile_dump.sv
// Walks an address window of the register file and streams the words out over valid/ready.
// Optional trailing XOR checksum beat when REGFILE_DUMP_CHECKSUM_EN is defined.
module regfile_dump
  import regfile_pkg::*;
#(
  parameter int BW_DATA = DEF_BW_DATA,
  parameter int BW_ADDR = DEF_BW_ADDR
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  regfile_dump_if.master  io_bus
);

  localparam logic [BW_ADDR-1:0] ADDR_ONE = BW_ADDR'(1);
  localparam logic [BW_ADDR:0]   CNT_ONE  = (BW_ADDR+1)'(1);
  localparam logic [BW_ADDR:0]   CNT_ZERO = {(BW_ADDR+1){1'b0}};
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam logic LAST_ON_WORD = 1'b0;
`else
  localparam logic LAST_ON_WORD = 1'b1;
`endif

  dump_state_e        r_state;
  logic [BW_ADDR-1:0] r_rd_addr;
  logic [BW_ADDR:0]   r_remaining;
  logic               r_dout_valid;
  logic [BW_DATA-1:0] r_dout_data;
  logic               r_dout_last;
  logic               r_busy;
  logic               r_done;

  logic w_hs;
  assign w_hs = r_dout_valid & io_bus.i_dout_ready;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic               w_capture;
  logic               w_clr;
  logic [BW_DATA-1:0] w_csum;

  assign w_capture = (r_state == ST_FETCH) |
                     ((r_state == ST_SEND) & w_hs & (r_remaining != CNT_ZERO));
  assign w_clr     = (r_state == ST_IDLE) & io_bus.i_start;

  regfile_dump_csum #(.BW_DATA(BW_DATA)) u_csum (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_clr  (w_clr),
    .i_en   (w_capture),
    .i_data (io_bus.i_rf_rd_data),
    .o_csum (w_csum)
  );
`endif

  // Dump sequencer; every output is a register updated here
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state      <= ST_IDLE;
      r_rd_addr    <= {BW_ADDR{1'b0}};
      r_remaining  <= CNT_ZERO;
      r_dout_valid <= 1'b0;
      r_dout_data  <= {BW_DATA{1'b0}};
      r_dout_last  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_dout_valid <= 1'b0;
          r_dout_last  <= 1'b0;
          r_done       <= 1'b0;
          if (io_bus.i_start) begin
            r_rd_addr   <= io_bus.i_base_addr;
            r_remaining <= io_bus.i_count;
            r_busy      <= 1'b1;
            if (io_bus.i_count != CNT_ZERO) begin
              r_state <= ST_FETCH;
            end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              r_state      <= ST_CSUM;
              r_dout_valid <= 1'b1;
              r_dout_data  <= {BW_DATA{1'b0}};
              r_dout_last  <= 1'b1;
`else
              // Empty dump still spends one cycle in DONE before the pulse
              r_state <= ST_DONE;
`endif
            end
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          r_dout_data  <= io_bus.i_rf_rd_data;
          r_rd_addr    <= r_rd_addr + ADDR_ONE;
          r_remaining  <= r_remaining - CNT_ONE;
          r_dout_valid <= 1'b1;
          r_dout_last  <= LAST_ON_WORD & (r_remaining == CNT_ONE);
          r_state      <= ST_SEND;
        end
        ST_SEND: begin
          if (w_hs) begin
            if (r_remaining != CNT_ZERO) begin
              r_dout_data <= io_bus.i_rf_rd_data;
              r_rd_addr   <= r_rd_addr + ADDR_ONE;
              r_remaining <= r_remaining - CNT_ONE;
              r_dout_last <= LAST_ON_WORD & (r_remaining == CNT_ONE);
              r_state     <= ST_SEND;
            end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              r_dout_data <= w_csum;
              r_dout_last <= 1'b1;
              r_state     <= ST_CSUM;
`else
              r_dout_valid <= 1'b0;
              r_dout_last  <= 1'b0;
              r_done       <= 1'b1;
              r_state      <= ST_DONE;
`endif
            end
          end else begin
            r_state <= ST_SEND;
          end
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        ST_CSUM: begin
          if (w_hs) begin
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= ST_DONE;
          end else begin
            r_state <= ST_CSUM;
          end
        end
`endif
        ST_DONE: begin
          // Entered with r_done already set after a final handshake
          if (r_done) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_dout_valid <= 1'b0;
          r_dout_last  <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.o_rf_rd_addr = r_rd_addr;
  assign io_bus.o_dout_valid = r_dout_valid;
  assign io_bus.o_dout_data  = r_dout_data;
  assign io_bus.o_dout_last  = r_dout_last;
  assign io_bus.o_busy       = r_busy;
  assign io_bus.o_done       = r_done;

endmodule
